// File: rtl/kamacore_hazard_ctrl_pkg.sv
// Shared kamacore datatypes used by the hazard/forwarding controller.
package kamacore_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned CPU_WIDTH      = 32;

    // Register-file source select: operand comes from the register file.
    localparam int unsigned FWD_SEL_RF     = 0;

    // One in-flight instruction as seen by the hazard scoreboard.
    typedef struct packed {
        logic                      valid;
        logic                      rd_we;
        logic [REG_ADDR_WIDTH-1:0] rd_a;
        logic                      is_load;
    } hazard_entry_t;

endpackage : kamacore_hazard_ctrl_pkg

// File: rtl/kamacore_hazard_ctrl_fwd_match.sv
// Priority matcher for one ID operand against the in-flight scoreboard.
// The youngest matching stage decides; a young load that is not yet
// forwardable blocks forwarding even when an older entry could supply data.
module kamacore_fwd_match
    import kamacore_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FWD_STAGES   = 3,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned SEL_WIDTH        = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                i_used,
    input  logic [REG_ADDR_WIDTH-1:0]           i_addr,
    input  hazard_entry_t [NUM_FWD_STAGES:1]    i_entries,
    output logic [SEL_WIDTH-1:0]                o_sel,
    output logic                                o_not_ready
);

    logic                 w_hit;
    logic                 w_fwd;
    logic [SEL_WIDTH-1:0] w_k;

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = 1'b0;
        w_k   = '0;
        for (int k = int'(NUM_FWD_STAGES); k >= 1; k--) begin
            if (i_used && (i_addr != '0) && i_entries[k].valid &&
                i_entries[k].rd_we && (i_entries[k].rd_a == i_addr)) begin
                w_hit = 1'b1;
                w_k   = SEL_WIDTH'(k);
                w_fwd = !i_entries[k].is_load || (k >= int'(LOAD_READY_STAGE));
            end
        end
    end

    assign o_sel       = (w_hit && w_fwd) ? w_k : SEL_WIDTH'(FWD_SEL_RF);
    assign o_not_ready = w_hit && !w_fwd;

endmodule : kamacore_fwd_match

// File: rtl/kamacore_hazard_ctrl.sv
// Hazard and forwarding controller: shadow scoreboard of in-flight
// destinations, forwarding selects, RAW/load-use stalls, branch flushes,
// backpressure freeze and stall/flush performance counters.
module kamacore_hazard_ctrl
    import kamacore_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FWD_STAGES   = 3,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned CNT_WIDTH        = 32,
    parameter int unsigned SEL_WIDTH        = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic                      id_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_a,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_a,
    input  logic                      id_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_a,
    input  logic                      id_is_load,
    input  logic                      branch_taken,
    input  logic                      mem_stall,
    output logic                      issue_ready,
    output logic                      stall_if,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic [SEL_WIDTH-1:0]      fwd_rs1_sel,
    output logic [SEL_WIDTH-1:0]      fwd_rs2_sel,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_events
);

    hazard_entry_t [NUM_FWD_STAGES:1] r_sb;
    logic [CNT_WIDTH-1:0]             r_stall_cycles;
    logic [CNT_WIDTH-1:0]             r_flush_events;

    logic          w_rs1_not_ready;
    logic          w_rs2_not_ready;
    logic          w_raw_stall;
    logic          w_issue_ready;
    logic          w_flush;
    hazard_entry_t w_new_entry;

    kamacore_fwd_match #(
        .NUM_FWD_STAGES   (NUM_FWD_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_WIDTH        (SEL_WIDTH)
    ) u_match_rs1 (
        .i_used      (id_rs1_used),
        .i_addr      (id_rs1_a),
        .i_entries   (r_sb),
        .o_sel       (fwd_rs1_sel),
        .o_not_ready (w_rs1_not_ready)
    );

    kamacore_fwd_match #(
        .NUM_FWD_STAGES   (NUM_FWD_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_WIDTH        (SEL_WIDTH)
    ) u_match_rs2 (
        .i_used      (id_rs2_used),
        .i_addr      (id_rs2_a),
        .i_entries   (r_sb),
        .o_sel       (fwd_rs2_sel),
        .o_not_ready (w_rs2_not_ready)
    );

    // A taken branch overrides a RAW stall: the stalled instruction is squashed.
    assign w_raw_stall   = id_valid && (w_rs1_not_ready || w_rs2_not_ready);
    assign w_issue_ready = !mem_stall && (!w_raw_stall || branch_taken);
    assign w_flush       = branch_taken && !mem_stall;

    assign issue_ready  = w_issue_ready;
    assign stall_if     = !w_issue_ready;
    assign flush_if_id  = w_flush;
    assign flush_id_ex  = w_flush;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    // Entry entering stage 1: the ID instruction if it really advances, else a bubble.
    always_comb begin
        w_new_entry = '0;
        if (id_valid && w_issue_ready && !branch_taken) begin
            w_new_entry.valid   = 1'b1;
            w_new_entry.rd_we   = id_rd_we;
            w_new_entry.rd_a    = id_rd_a;
            w_new_entry.is_load = id_is_load;
        end
    end

    // Scoreboard shift; the whole pipe freezes under memory backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else if (!mem_stall) begin
            for (int k = int'(NUM_FWD_STAGES); k >= 2; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_sb[1] <= w_new_entry;
        end
    end

    // Performance counters, wrapping naturally at full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_issue_ready) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (w_flush) begin
                r_flush_events <= r_flush_events + CNT_WIDTH'(1);
            end
        end
    end

endmodule : kamacore_hazard_ctrl

// File: doc/kamacore_hazard_ctrl.md
Name: kamacore_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the kamacore in-order pipeline, generalised over forwarding depth and load latency. It sits beside the stage instances in the core top and owns a shadow scoreboard of in-flight destination registers. Each cycle it issues forwarding selects, RAW/load-use stalls, branch flushes and backpressure freezes for the ID stage. It also keeps stall and flush performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register address width (from shared package)
NUM_FWD_STAGES, 3, tracked stages after ID; 1=EX, 2=MEM, ..., N=WB
LOAD_READY_STAGE, 2, first tracked stage at which load data is forwardable
CNT_WIDTH, 32, performance counter width
SEL_WIDTH, $clog2(NUM_FWD_STAGES+1), forwarding select width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1_used  in  1  instruction reads rs1
id_rs1_a  in  REG_ADDR_WIDTH  rs1 address
id_rs2_used  in  1  instruction reads rs2
id_rs2_a  in  REG_ADDR_WIDTH  rs2 address
id_rd_we  in  1  instruction writes rd
id_rd_a  in  REG_ADDR_WIDTH  rd address
id_is_load  in  1  instruction is a load
branch_taken  in  1  EX resolved a taken branch/jump
mem_stall  in  1  memory stage backpressure; whole back end frozen
issue_ready  out  1  ID may advance into EX this cycle
stall_if  out  1  hold PC and IF/ID register (= !issue_ready)
flush_if_id  out  1  squash IF/ID contents
flush_id_ex  out  1  insert bubble into ID/EX
fwd_rs1_sel  out  SEL_WIDTH  0 = register file, k = tracked stage k
fwd_rs2_sel  out  SEL_WIDTH  as above for rs2
stall_cycles  out  CNT_WIDTH  cycles with issue_ready=0
flush_events  out  CNT_WIDTH  number of accepted flushes

Behaviour:
- Scoreboard: entry[1..N] = {valid, rd_we, rd_a, is_load}. Registered; all other outputs are combinational from the scoreboard and inputs.
- Reset (rst high at posedge): all entries invalid; counters 0.
  - Resulting outputs: issue_ready=1, stall_if=0, flush_if_id=0, flush_id_ex=0, fwd_rs*_sel=0.
- Match rule for an operand: used && addr!=0 && entry[k].valid && rd_we && rd_a==addr.
  - The youngest (smallest k) matching entry wins, even if it is not forwardable and an older entry is.
  - Writes to x0 never match.
- Forwardable: entry is not a load, or k >= LOAD_READY_STAGE.
- fwd_sel = winning k if forwardable, else 0. If no match, fwd_sel = 0.
- raw_stall = id_valid && some used operand has a non-forwardable youngest match.
- issue_ready = !mem_stall && (!raw_stall || branch_taken).
- Flush: flush_if_id = flush_id_ex = branch_taken && !mem_stall.
  - While mem_stall is high, EX holds branch_taken asserted until the stall releases.
- Update when !mem_stall:
  - entry[k+1] <= entry[k]; entry[N] retires.
  - entry[1] <= ID instruction if id_valid && issue_ready && !branch_taken, else a bubble (valid=0).
- Update when mem_stall: all entries hold; fwd selects are stable.
- Load-use latency: with defaults, a consumer immediately after a load stalls exactly 1 cycle, then receives sel=2.
- Counters:
  - stall_cycles += 1 each cycle issue_ready=0, including mem_stall cycles.
  - flush_events += 1 each cycle flush_if_id=1.
  - Both wrap modulo 2^CNT_WIDTH.
- rst mid-operation: in-flight entries are dropped and counters cleared in the same edge; no flush is emitted.

Decomposition:
- Shared package kamacore_datatypes.svh (REG_ADDR_WIDTH, CPU_WIDTH already there) gains:
  - typedef struct packed hazard_entry_t {valid, rd_we, rd_a, is_load};
  - localparam FWD_SEL_RF = 0.
- Sub-module kamacore_fwd_match: combinational priority matcher over the scoreboard for one operand. Outputs sel and not-ready; instantiated twice (rs1, rs2).
- Scoreboard, stall/flush logic and counters stay in kamacore_hazard_ctrl.

Test Plan:
- rst 2 cycles, then idle -> issue_ready=1, fwd sels 0, flushes 0, stall_cycles=0, flush_events=0.
- Issue ADD x5, next cycle ID reads rs1=x5 -> fwd_rs1_sel=1, issue_ready=1; following cycle a rs2=x5 reader gets fwd_rs2_sel=2.
- Issue LW x6, next ID uses rs1=x6 -> issue_ready=0 and stall_if=1 for one cycle, stall_cycles=1; next cycle fwd_rs1_sel=2, issue_ready=1.
- Write x0 then read rs1=x0 -> fwd_rs1_sel=0, no stall; x7 in entry1 and entry2, read x7 -> sel=1.
- Load-use stall coinciding with branch_taken=1 -> flush_if_id=flush_id_ex=1, issue_ready=1, entry[1] bubble next cycle, flush_events=1.
- mem_stall high 3 cycles with a forwarded operand -> scoreboard frozen, sel constant, issue_ready=0, stall_cycles +3; branch_taken during the stall produces a flush only in the release cycle.
